// File: rtl/uart_arb_pkg.sv
// Shared types and sizing helpers for the uart_tx arbiter.
// Counter width covers the larger of the gap length and the start timeout.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  localparam int DEF_GAP_CYCLES = 255;
  localparam int DEF_START_TO   = 64;

  function automatic int cnt_width(input int gap_cycles, input int start_to);
    int top;
    top = (gap_cycles > start_to) ? gap_cycles : start_to;
    return (top < 1) ? 1 : $clog2(top + 1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: first asserted request after ptr, wrapping.
// Produces both the winning index and its one-hot form.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx,
  output logic [NUM_REQ-1:0] onehot
);

  logic [NUM_REQ-1:0] rot;
  int                 pos;

  // Rotate so bit 0 is the source just after ptr; lowest set bit then wins.
  always_comb begin
    any = 1'b0;
    pos = 0;
    rot = NUM_REQ'({req, req} >> (int'(ptr) + 1));
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        any = 1'b1;
        pos = j;
      end
    end
    idx = IDX_W'((int'(ptr) + 1 + pos) % NUM_REQ);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign onehot[gi] = any && (idx == IDX_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one uart_tx byte transmitter.
// Sequences tx_pluse/tx_data, tracks synchronised busy edges, gap and start timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int IDX_W      = $clog2(NUM_REQ),
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int START_TO   = DEF_START_TO
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_pluse,
  input  logic                   tx_busy,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   locked,
  output logic                   err_timeout
);

  localparam int CNT_W = cnt_width(GAP_CYCLES, START_TO);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'((GAP_CYCLES > START_TO) ? GAP_CYCLES : START_TO);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(START_TO - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t               state_reg, state_next;
  logic                 busy_d0, busy_d1;
  logic                 busy_rise, busy_fall;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     ptr_reg, ptr_next;
  logic [7:0]           tx_data_next;
  logic                 tx_pluse_next;
  logic [NUM_REQ-1:0]   req_ready_next;
  logic [IDX_W-1:0]     grant_next;
  logic                 locked_next;
  logic                 err_next;

  logic [7:0]           src_data [NUM_REQ];
  logic [NUM_REQ-1:0]   owner_onehot;
  logic [NUM_REQ-1:0]   arb_onehot;
  logic [NUM_REQ-1:0]   sel_onehot;
  logic [IDX_W-1:0]     arb_idx, sel_idx;
  logic                 arb_any, sel_valid, sel_last;
  logic                 timeout_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_src
      assign src_data[gi]     = req_data[8*gi +: 8];
      assign owner_onehot[gi] = (grant_idx == IDX_W'(gi));
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req    (req_valid),
    .ptr    (ptr_reg),
    .any    (arb_any),
    .idx    (arb_idx),
    .onehot (arb_onehot)
  );

  // While a packet is open only the owner is considered; others are invisible.
  assign sel_idx    = locked ? grant_idx : arb_idx;
  assign sel_valid  = locked ? req_valid[grant_idx] : arb_any;
  assign sel_onehot = locked ? owner_onehot : arb_onehot;
  assign sel_last   = req_last[sel_idx];

  assign busy_rise   = busy_d0 & ~busy_d1;
  assign busy_fall   = ~busy_d0 & busy_d1;
  assign timeout_hit = (state_reg == WAIT_BUSY) && !busy_rise && (cnt_reg == TO_LAST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (sel_valid) state_next = LOAD;
      LOAD:      state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (busy_rise)        state_next = WAIT_DONE;
        else if (timeout_hit) state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      WAIT_DONE: if (busy_fall) state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:       if (cnt_reg == GAP_LAST) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Outputs are registered: the IDLE decision loads them so they show during LOAD.
  always_comb begin
    tx_data_next   = tx_data;
    tx_pluse_next  = 1'b0;
    req_ready_next = '0;
    grant_next     = grant_idx;
    locked_next    = locked;
    ptr_next       = ptr_reg;
    err_next       = timeout_hit;
    if (state_reg == IDLE && sel_valid) begin
      grant_next     = sel_idx;
      tx_data_next   = src_data[sel_idx];
      tx_pluse_next  = 1'b1;
      req_ready_next = sel_onehot;
      if (sel_last) begin
        locked_next = 1'b0;
        ptr_next    = sel_idx;
      end else begin
        locked_next = 1'b1;
      end
    end
    // Counter restarts at LOAD (start timeout) and at GAP entry; saturates otherwise.
    if (state_next == LOAD || (state_next == GAP && state_reg != GAP)) begin
      cnt_next = '0;
    end else if (cnt_reg != CNT_MAX) begin
      cnt_next = cnt_reg + 1'b1;
    end else begin
      cnt_next = cnt_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy_d0     <= 1'b0;
      busy_d1     <= 1'b0;
      cnt_reg     <= '0;
      ptr_reg     <= IDX_W'(NUM_REQ - 1);
      tx_data     <= '0;
      tx_pluse    <= 1'b0;
      req_ready   <= '0;
      grant_idx   <= '0;
      locked      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      busy_d0     <= tx_busy;
      busy_d1     <= busy_d0;
      cnt_reg     <= cnt_next;
      ptr_reg     <= ptr_next;
      tx_data     <= tx_data_next;
      tx_pluse    <= tx_pluse_next;
      req_ready   <= req_ready_next;
      grant_idx   <= grant_next;
      locked      <= locked_next;
      err_timeout <= err_next;
    end
  end

endmodule
